// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder controller and its bench.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package serial_add_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_full_adder_cell.sv
// One-bit full adder: two half adders with the two carries OR-ed together.
// Latency: purely combinational.
// Backpressure: none.
module half_adder (
    input  logic i_x,
    input  logic i_y,
    output logic o_s,
    output logic o_c
);
    assign o_s = i_x ^ i_y;
    assign o_c = i_x & i_y;
endmodule

module full_adder_cell (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_s,
    output logic o_cout
);
    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .i_x (i_a),
        .i_y (i_b),
        .o_s (w_s0),
        .o_c (w_c0)
    );

    half_adder u_ha1 (
        .i_x (w_s0),
        .i_y (i_cin),
        .o_s (o_s),
        .o_c (w_c1)
    );

    assign o_cout = w_c0 | w_c1;
endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB-first through one full-adder cell.
// Latency: start accepted at edge N -> done (and valid sum/cout) in cycle N+WIDTH+1.
// Backpressure: none; start is ignored while busy. SERIAL_ADD_SUB_EN adds a 'sub' input for a-b.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef SERIAL_ADD_SUB_EN
    input  logic             sub,
`endif
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);
    localparam int              CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_busy;
    logic             w_done;
    logic             w_fa_s;
    logic             w_fa_c;
    logic [WIDTH-1:0] w_sb_load;
    logic             w_carry_init;

    // Subtraction is a + ~b + 1, so only the B load value and the initial carry change.
`ifdef SERIAL_ADD_SUB_EN
    assign w_sb_load    = sub ? ~b : b;
    assign w_carry_init = sub;
`else
    assign w_sb_load    = b;
    assign w_carry_init = 1'b0;
`endif

    full_adder_cell u_fa (
        .i_a    (r_sa[0]),
        .i_b    (r_sb[0]),
        .i_cin  (r_carry),
        .o_s    (w_fa_s),
        .o_cout (w_fa_c)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and status decode.
    always_comb begin
        w_state_nxt = r_state;
        w_busy      = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_busy = 1'b1;
                if (r_cnt == LAST) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_busy      = 1'b1;
                w_done      = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Operand capture, serial shifting and result accumulation.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sa    <= '0;
            r_sb    <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sa    <= a;
                        r_sb    <= w_sb_load;
                        r_carry <= w_carry_init;
                        r_cnt   <= '0;
                    end
                end
                ST_RUN: begin
                    r_sa    <= r_sa >> 1;
                    r_sb    <= r_sb >> 1;
                    r_carry <= w_fa_c;
                    r_sum   <= {w_fa_s, r_sum[WIDTH-1:1]};
                    // Counter parks on the last bit rather than wrapping.
                    if (r_cnt == LAST) begin
                        r_cout <= w_fa_c;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;
    assign busy = w_busy;
    assign done = w_done;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl at WIDTH=4 against an arithmetic reference.
// Latency: checks done arrives WIDTH edges after the accepting edge.
// Backpressure: checks that start while busy is ignored.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W    = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
`ifdef SERIAL_ADD_SUB_EN
    logic         sub;
`endif
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;
    logic         done;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
`ifdef SERIAL_ADD_SUB_EN
        .sub   (sub),
`endif
        .a     (a),
        .b     (b),
        .sum   (sum),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: plain modular arithmetic; for subtraction cout means a>=b.
    function automatic void model(input int x, input int y, input bit s,
                                  output int es, output int ec);
        if (s) begin
            es = (x - y) & MASK;
            ec = (x >= y) ? 1 : 0;
        end else begin
            es = (x + y) & MASK;
            ec = (x + y) >> W;
        end
    endfunction

    task automatic drive(input int x, input int y, input bit s);
        a = W'(x);
        b = W'(y);
`ifdef SERIAL_ADD_SUB_EN
        sub = s;
`else
        if (s) begin
            a = W'(x);
        end
`endif
    endtask

    // One full operation from IDLE, with timing and result checks.
    task automatic do_op(input int x, input int y, input bit s, input string tag);
        int es, ec, k, nbusy;
        model(x, y, s, es, ec);
        drive(x, y, s);
        start = 1'b1;
        tick();
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        nbusy = busy ? 1 : 0;
        k = 0;
        while (!done && k < 3 * W) begin
            tick();
            k++;
            if (busy) nbusy++;
        end
        chk({tag, "_latency"}, k, W);
        chk({tag, "_busycycles"}, nbusy, W + 1);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        tick();
        chk({tag, "_done_low"}, done, 0);
        chk({tag, "_busy_low"}, busy, 0);
    endtask

    initial begin
        int es, ec, npulse, k;
        reset = 1'b1;
        start = 1'b0;
        drive(0, 0, 1'b0);
        tick();
        tick();
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", dut.r_state, ST_IDLE);
        reset = 1'b0;
        tick();

        do_op(3, 5, 1'b0, "add_3_5");
        do_op(15, 1, 1'b0, "add_15_1");
        do_op(0, 0, 1'b0, "add_0_0");

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                do_op(x, y, 1'b0, "sweep");
            end
        end

        // start re-pulsed two cycles into RUN with different operands
        model(6, 7, 1'b0, es, ec);
        drive(6, 7, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        drive(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        npulse = 0;
        k = 0;
        while (!done && k < 3 * W) begin
            tick();
            k++;
        end
        if (done) npulse++;
        chk("busy_start_sum", sum, es);
        chk("busy_start_cout", cout, ec);
        for (int i = 0; i < W + 4; i++) begin
            tick();
            if (done) npulse++;
        end
        chk("busy_start_pulses", npulse, 1);
        chk("busy_start_idle", dut.r_state, ST_IDLE);

        // reset on the third RUN cycle
        drive(9, 4, 1'b0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        chk("midrst_sum", sum, 0);
        chk("midrst_cout", cout, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_state", dut.r_state, ST_IDLE);
        reset = 1'b0;
        do_op(2, 11, 1'b0, "after_rst");

        // start held high: back-to-back operations every W+2 cycles
        drive(7, 9, 1'b0);
        start = 1'b1;
        npulse = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (done) begin
                chk("held_pulse_pos", i, 5 + 6 * npulse);
                chk("held_sum", sum, 0);
                chk("held_cout", cout, 1);
                npulse++;
            end
        end
        start = 1'b0;
        chk("held_pulses", npulse, 3);
        k = 0;
        while (busy && k < 3 * W) begin
            tick();
            k++;
        end
        chk("held_drain_idle", busy, 0);

`ifdef SERIAL_ADD_SUB_EN
        do_op(5, 3, 1'b1, "sub_5_3");
        do_op(3, 5, 1'b1, "sub_3_5");
`endif

        for (int i = 0; i < 40; i++) begin
`ifdef SERIAL_ADD_SUB_EN
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                  bit'($urandom_range(0, 1)), "rand");
`else
            do_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'b0, "rand");
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial adder controller: accepts two WIDTH-bit operands on a start pulse and adds them LSB-first over WIDTH cycles.
- Uses one full-adder cell (two half adders plus an OR) and a registered carry; the controller sequences the cell.
- Returns the sum, carry-out and a one-cycle done pulse.
- Sits between a requester (testbench or host FSM) and the 1-bit adder datapath, reusing the half-adder primitive instead of a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand and sum width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- sum  output  WIDTH  result, registered, held until next accepted start
- cout  output  1  final carry-out, registered, held like sum
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse in DONE

Behaviour:
- Clocking: one clock; reset is synchronous and active-high, sampled on rising clk.
- Reset values: state=IDLE, sum=0, cout=0, busy=0, done=0, internal shift regs=0, carry=0, bit counter=0.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> capture a into shift reg SA, b into SB, carry=0, cnt=0; next RUN. start=0 -> stay.
- RUN, each cycle:
  - s = SA[0]^SB[0]^carry via the full-adder cell.
  - carry <= cell carry; SA, SB shift right by 1; s shifts into sum shift reg at the MSB.
  - cnt <= cnt+1.
  - When cnt==WIDTH-1 the final bit is processed this cycle: next DONE; cout <= cell carry.
- DONE: done=1 for exactly one cycle, busy=1; next IDLE unconditionally.
- Latency: start accepted at edge N -> done high in cycle N+WIDTH+1; sum/cout valid from that cycle.
- Counter width: $clog2(WIDTH); no wrap beyond WIDTH-1.
- sum is updated only by the shift in RUN. Its intermediate value during RUN is not meaningful. The final value is held through IDLE until the next accepted start.
- Boundary conditions:
  - start while busy (RUN or DONE): ignored, no queuing.
  - start held high continuously: a new operation begins each time IDLE is reached (back-to-back every WIDTH+2 cycles).
  - a/b changes after capture: no effect on the current operation.
  - reset asserted mid-RUN or in DONE: all outputs and state return to reset values on that edge; no done pulse is emitted.
  - reset and start in the same cycle: reset wins.
  - Overflow: result is modulo 2^WIDTH; the carry appears on cout.

Optional Feature:
- Macro: SERIAL_ADD_SUB_EN.
- Defined:
  - Extra input port sub (1 bit), captured with the operands.
  - sub=1 -> SB loads ~b and the initial carry is 1, giving sum = a-b mod 2^WIDTH; cout=1 means no borrow (a>=b).
  - sub=0 -> identical to addition.
- Not defined: no sub port; addition only; logic is absent.

Decomposition:
- Shared package (serial_add_pkg): state encoding constants (ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2) and the default WIDTH constant, shared with the bench for state checks.
- One sub-module: full_adder_cell, built from two half_adder instances plus an OR for carry. The controller instantiates it once.

Test Plan:
- WIDTH=4, reset 2 cycles, then a=3, b=5, start 1 cycle -> done pulse exactly 5 cycles after the accepting edge; sum=8, cout=0; busy high for 5 cycles.
- WIDTH=4, a=15, b=1 -> sum=0, cout=1. Then a=0, b=0 -> sum=0, cout=0. Exhaustively sweep all 256 pairs against a+b.
- Start pulsed again 2 cycles into RUN with different operands -> ignored; result matches the first operands; only one done pulse.
- Reset asserted on the 3rd RUN cycle -> next cycle sum=0, cout=0, busy=0, done=0, state IDLE; a following start completes normally.
- start held high for 20 cycles with a=7, b=9 -> done pulses every 6 cycles, each with sum=0 and cout=1 (16 mod 16).
- With SERIAL_ADD_SUB_EN: a=5, b=3, sub=1 -> sum=2, cout=1; a=3, b=5, sub=1 -> sum=14, cout=0.
